// File: rtl/mcb_port_responder_if.sv
// MCB-style user port: command, write-data and read-data FIFO signals.
// The responder takes the slave side; a port master or testbench drives the master side.
interface mcb_port_responder_if;
   logic        cmd_en;
   logic [2:0]  cmd_instr;
   logic [5:0]  cmd_bl;
   logic [27:0] cmd_word_addr;
   logic        cmd_empty;
   logic        cmd_full;

   logic        wr_en;
   logic [3:0]  wr_mask;
   logic [31:0] wr_data;
   logic        wr_full;
   logic        wr_empty;
   logic [6:0]  wr_count;
   logic        wr_underrun;
   logic        wr_error;

   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_full;
   logic        rd_empty;
   logic [6:0]  rd_count;
   logic        rd_overflow;
   logic        rd_error;

   modport slave (
      input  cmd_en, cmd_instr, cmd_bl, cmd_word_addr, wr_en, wr_mask, wr_data, rd_en,
      output cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
      output rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
   );

   modport master (
      output cmd_en, cmd_instr, cmd_bl, cmd_word_addr, wr_en, wr_mask, wr_data, rd_en,
      input  cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
      input  rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
   );
endinterface

// File: rtl/mcb_port_responder.sv
// Block-RAM backed MCB user-port responder: commands execute strictly in order.
// Reads land in the read FIFO three edges after the command push; writes stall on an empty write FIFO.
module mcb_port_responder #(
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int CMD_FIFO_DEPTH = 4,
   parameter int REFRESH_CYCLES = 8
) (
   input logic                 clk,
   input logic                 rst,
   mcb_port_responder_if.slave bus
);
   localparam int CPW   = $clog2(CMD_FIFO_DEPTH);
   localparam int RFW   = $clog2(REFRESH_CYCLES + 1);
   localparam int REM_W = (RFW > 7) ? RFW : 7;

   typedef struct packed {
      logic [2:0]                instr;
      logic [5:0]                bl;
      logic [MEM_ADDR_WIDTH-1:0] addr;
   } cmd_t;

   typedef struct packed {
      logic [3:0]  mask;
      logic [31:0] data;
   } wr_word_t;

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_REFRESH} state_t;

   cmd_t                      r_cmd_mem [CMD_FIFO_DEPTH];
   logic [CPW-1:0]            r_cmd_wp, r_cmd_rp;
   logic [CPW:0]              r_cmd_cnt;
   wr_word_t                  r_wr_mem [64];
   logic [5:0]                r_wr_wp, r_wr_rp;
   logic [6:0]                r_wr_cnt;
   logic                      r_wr_error;
   logic [31:0]               r_rd_mem [64];
   logic [5:0]                r_rd_wp, r_rd_rp;
   logic [6:0]                r_rd_cnt;
   logic                      r_rd_overflow, r_rd_error;
   logic [31:0]               r_mem [2**MEM_ADDR_WIDTH];
   logic [31:0]               r_ram_q;
   logic                      r_ram_vld;
   state_t                    r_state;
   logic [MEM_ADDR_WIDTH-1:0] r_addr;
   logic [REM_W-1:0]          r_remain;

   logic     w_cmd_empty, w_cmd_full, w_cmd_push, w_cmd_pop;
   logic     w_wr_empty, w_wr_full, w_wr_push, w_wr_pop;
   logic     w_rd_empty, w_rd_full, w_rd_push, w_rd_pop;
   cmd_t     w_cmd_head;
   wr_word_t w_wr_head;
   logic     w_addr_unused;

   assign w_addr_unused = ^bus.cmd_word_addr[27:MEM_ADDR_WIDTH];

   assign w_cmd_empty = (r_cmd_cnt == '0);
   assign w_cmd_full  = (r_cmd_cnt == (CPW+1)'(CMD_FIFO_DEPTH));
   assign w_cmd_push  = bus.cmd_en && !w_cmd_full;
   // Holding off the pop while a RAM read is in flight keeps the read FIFO strictly ordered.
   assign w_cmd_pop   = (r_state == S_IDLE) && !w_cmd_empty && !r_ram_vld;
   assign w_cmd_head  = r_cmd_mem[r_cmd_rp];

   assign w_wr_empty = (r_wr_cnt == 7'd0);
   assign w_wr_full  = (r_wr_cnt == 7'd64);
   assign w_wr_push  = bus.wr_en && !w_wr_full;
   assign w_wr_pop   = (r_state == S_WRITE) && !w_wr_empty;
   assign w_wr_head  = r_wr_mem[r_wr_rp];

   assign w_rd_empty = (r_rd_cnt == 7'd0);
   assign w_rd_full  = (r_rd_cnt == 7'd64);
   assign w_rd_push  = r_ram_vld && !w_rd_full;
   assign w_rd_pop   = bus.rd_en && !w_rd_empty;

   assign bus.cmd_empty   = w_cmd_empty;
   assign bus.cmd_full    = w_cmd_full;
   assign bus.wr_empty    = w_wr_empty;
   assign bus.wr_full     = w_wr_full;
   assign bus.wr_count    = r_wr_cnt;
   assign bus.wr_underrun = (r_state == S_WRITE) && w_wr_empty;
   assign bus.wr_error    = r_wr_error;
   assign bus.rd_empty    = w_rd_empty;
   assign bus.rd_full     = w_rd_full;
   assign bus.rd_count    = r_rd_cnt;
   assign bus.rd_overflow = r_rd_overflow;
   assign bus.rd_error    = r_rd_error;
   assign bus.rd_data     = w_rd_empty ? '0 : r_rd_mem[r_rd_rp];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmd_wp  <= '0;
         r_cmd_rp  <= '0;
         r_cmd_cnt <= '0;
      end else begin
         if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wp] <= '{instr: bus.cmd_instr, bl: bus.cmd_bl,
                                     addr: bus.cmd_word_addr[MEM_ADDR_WIDTH-1:0]};
            r_cmd_wp <= r_cmd_wp + CPW'(1);
         end
         if (w_cmd_pop) r_cmd_rp <= r_cmd_rp + CPW'(1);
         r_cmd_cnt <= r_cmd_cnt + (CPW+1)'(w_cmd_push) - (CPW+1)'(w_cmd_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_wp    <= '0;
         r_wr_rp    <= '0;
         r_wr_cnt   <= '0;
         r_wr_error <= 1'b0;
      end else begin
         if (w_wr_push) begin
            r_wr_mem[r_wr_wp] <= '{mask: bus.wr_mask, data: bus.wr_data};
            r_wr_wp <= r_wr_wp + 6'd1;
         end
         if (bus.wr_en && w_wr_full) r_wr_error <= 1'b1;
         if (w_wr_pop) r_wr_rp <= r_wr_rp + 6'd1;
         r_wr_cnt <= r_wr_cnt + 7'(w_wr_push) - 7'(w_wr_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_wp       <= '0;
         r_rd_rp       <= '0;
         r_rd_cnt      <= '0;
         r_rd_overflow <= 1'b0;
         r_rd_error    <= 1'b0;
      end else begin
         if (w_rd_push) begin
            r_rd_mem[r_rd_wp] <= r_ram_q;
            r_rd_wp <= r_rd_wp + 6'd1;
         end
         if (r_ram_vld && w_rd_full) r_rd_overflow <= 1'b1;
         if (bus.rd_en && w_rd_empty) r_rd_error <= 1'b1;
         if (w_rd_pop) r_rd_rp <= r_rd_rp + 6'd1;
         r_rd_cnt <= r_rd_cnt + 7'(w_rd_push) - 7'(w_rd_pop);
      end
   end

   // Backing store is deliberately left out of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_pop) begin
         for (int b = 0; b < 4; b++) begin
            if (!w_wr_head.mask[b]) r_mem[r_addr][b*8 +: 8] <= w_wr_head.data[b*8 +: 8];
         end
      end
      if (r_state == S_READ) r_ram_q <= r_mem[r_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_remain  <= '0;
         r_ram_vld <= 1'b0;
      end else begin
         r_ram_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cmd_pop) begin
                  r_addr   <= w_cmd_head.addr;
                  r_remain <= REM_W'(w_cmd_head.bl) + REM_W'(1);
                  case (w_cmd_head.instr)
                     3'b000, 3'b010: r_state <= S_WRITE;
                     3'b001, 3'b011: r_state <= S_READ;
                     3'b100: begin
                        r_state  <= S_REFRESH;
                        r_remain <= REM_W'(REFRESH_CYCLES);
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
            S_WRITE: begin
               if (w_wr_pop) begin
                  r_addr   <= r_addr + MEM_ADDR_WIDTH'(1);
                  r_remain <= r_remain - REM_W'(1);
                  if (r_remain <= REM_W'(1)) r_state <= S_IDLE;
               end
            end
            S_READ: begin
               r_ram_vld <= 1'b1;
               r_addr    <= r_addr + MEM_ADDR_WIDTH'(1);
               r_remain  <= r_remain - REM_W'(1);
               if (r_remain <= REM_W'(1)) r_state <= S_IDLE;
            end
            S_REFRESH: begin
               r_remain <= r_remain - REM_W'(1);
               if (r_remain <= REM_W'(1)) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
